// File: rtl/l2_pri_bank_arbiter.sv
`default_nettype none
// l2_pri_bank_arbiter -- two-port round-robin front end for a private L2 bank
// with a built-in zero-initialisation sweep.  Rev 1.0
module l2_pri_bank_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH/8,
  parameter int INIT_WORDS = 8192
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    init_req_i,
  output logic                    init_busy_o,
  output logic                    init_done_o,
  input  logic [1:0]              req_i,
  output logic [1:0]              gnt_o,
  input  logic [2*ADDR_WIDTH-1:0] add_i,
  input  logic [1:0]              wen_i,
  input  logic [2*BE_WIDTH-1:0]   be_i,
  input  logic [2*DATA_WIDTH-1:0] wdata_i,
  output logic [1:0]              r_valid_o,
  output logic [DATA_WIDTH-1:0]   r_rdata_o,
  output logic                    mem_csn_o,
  output logic                    mem_wen_o,
  output logic [BE_WIDTH-1:0]     mem_ben_o,
  output logic [ADDR_WIDTH-1:0]   mem_add_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam logic [0:0] SERVE = 1'b0;
  localparam logic [0:0] INIT  = 1'b1;

  // One extra bit so a full-bank sweep reaches its last index without wrapping.
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(INIT_WORDS - 1);

  logic [0:0]          state;
  logic [0:0]          next_state;
  logic [ADDR_WIDTH:0] cnt;
  logic                prio;
  logic                rsp_valid;
  logic                rsp_id;
  logic                done_q;
  logic                last_word;
  logic [1:0]          gnt;
  logic                sel;

  assign last_word = (state == INIT) && (cnt == CNT_LAST);
  assign sel       = gnt[1];

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= SERVE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      SERVE:   if (init_req_i) next_state = INIT;
      INIT:    if (last_word)  next_state = SERVE;
      default: next_state = SERVE;
    endcase
  end

  // prio names the port that wins a tie; it moves away from whoever was granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt       <= '0;
      prio      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt       <= ((state == INIT) && !last_word) ? cnt + 1'b1 : '0;
      if (|gnt) prio <= ~gnt[1];
      rsp_valid <= |gnt;
      rsp_id    <= gnt[1];
      done_q    <= last_word;
    end
  end

  // Output logic; reset gates the combinational paths so the bank idles at once.
  always_comb begin
    gnt         = 2'b00;
    mem_csn_o   = 1'b1;
    mem_wen_o   = 1'b1;
    mem_ben_o   = '1;
    mem_add_o   = '0;
    mem_wdata_o = '0;
    if (rst_ni) begin
      case (state)
        SERVE: begin
          if (req_i == 2'b11) gnt = prio ? 2'b10 : 2'b01;
          else                gnt = req_i;
          if (|gnt) begin
            mem_csn_o   = 1'b0;
            mem_wen_o   = sel ? wen_i[1] : wen_i[0];
            mem_ben_o   = sel ? ~be_i[2*BE_WIDTH-1:BE_WIDTH] : ~be_i[BE_WIDTH-1:0];
            mem_add_o   = sel ? add_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : add_i[ADDR_WIDTH-1:0];
            mem_wdata_o = sel ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0];
          end
        end
        INIT: begin
          mem_csn_o = 1'b0;
          mem_wen_o = 1'b0;
          mem_ben_o = '0;
          mem_add_o = cnt[ADDR_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign gnt_o       = gnt;
  assign init_busy_o = (state == INIT);
  assign init_done_o = done_q;
  assign r_valid_o   = {rsp_valid & rsp_id, rsp_valid & ~rsp_id};
  assign r_rdata_o   = rsp_valid ? mem_rdata_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_l2_pri_bank_arbiter.sv
`default_nettype none
// tb_l2_pri_bank_arbiter -- directed vector table plus init/reset sequences
// against a behavioural one-cycle-latency bank.
module tb_l2_pri_bank_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int IW = 16;
  localparam logic [31:0] WD0 = 32'h0BAD_F00D;

  logic          clk;
  logic          rst_ni;
  logic          init_req_i;
  logic          init_busy_o;
  logic          init_done_o;
  logic [1:0]    req_i;
  logic [1:0]    gnt_o;
  logic [2*AW-1:0] add_i;
  logic [1:0]    wen_i;
  logic [2*BW-1:0] be_i;
  logic [2*DW-1:0] wdata_i;
  logic [1:0]    r_valid_o;
  logic [DW-1:0] r_rdata_o;
  logic          mem_csn_o;
  logic          mem_wen_o;
  logic [BW-1:0] mem_ben_o;
  logic [AW-1:0] mem_add_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  logic [DW-1:0] bank [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  l2_pri_bank_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .INIT_WORDS(IW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .init_req_i(init_req_i), .init_busy_o(init_busy_o), .init_done_o(init_done_o),
    .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i), .wen_i(wen_i), .be_i(be_i),
    .wdata_i(wdata_i), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o),
    .mem_csn_o(mem_csn_o), .mem_wen_o(mem_wen_o), .mem_ben_o(mem_ben_o),
    .mem_add_o(mem_add_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_csn_o) begin
      if (!mem_wen_o) begin
        for (int b = 0; b < BW; b++)
          if (!mem_ben_o[b]) bank[mem_add_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= bank[mem_add_o];
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wen;
    logic [7:0]  add0;
    logic [7:0]  add1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [1:0]  gnt;
    logic        csn;
    logic        mwen;
    logic [3:0]  ben;
    logic [7:0]  madd;
    logic [31:0] mwd;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic        chk;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int n;
    int pulses;

    // req, wen, add0, add1, be1, wd1 | gnt, csn, wen, ben, add, wdata | rvalid, rdata, chk
    vecs[0]  = '{2'b11, 2'b11, 8'h01, 8'h02, 4'hF, 32'h0,        2'b01, 1'b0, 1'b1, 4'h0, 8'h01, WD0,          2'b00, 32'h0,        1'b1};
    vecs[1]  = '{2'b11, 2'b11, 8'h01, 8'h02, 4'hF, 32'h0,        2'b10, 1'b0, 1'b1, 4'h0, 8'h02, 32'h0,        2'b01, 32'hFFFFFFFF, 1'b1};
    vecs[2]  = '{2'b11, 2'b11, 8'h01, 8'h02, 4'hF, 32'h0,        2'b01, 1'b0, 1'b1, 4'h0, 8'h01, WD0,          2'b10, 32'hFFFFFFFF, 1'b1};
    vecs[3]  = '{2'b11, 2'b11, 8'h01, 8'h02, 4'hF, 32'h0,        2'b10, 1'b0, 1'b1, 4'h0, 8'h02, 32'h0,        2'b01, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{2'b11, 2'b11, 8'h01, 8'h02, 4'hF, 32'h0,        2'b01, 1'b0, 1'b1, 4'h0, 8'h01, WD0,          2'b10, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{2'b11, 2'b11, 8'h01, 8'h02, 4'hF, 32'h0,        2'b10, 1'b0, 1'b1, 4'h0, 8'h02, 32'h0,        2'b01, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{2'b01, 2'b11, 8'h05, 8'h00, 4'hF, 32'h0,        2'b01, 1'b0, 1'b1, 4'h0, 8'h05, WD0,          2'b10, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{2'b00, 2'b11, 8'h00, 8'h00, 4'hF, 32'h0,        2'b00, 1'b1, 1'b1, 4'hF, 8'h00, 32'h0,        2'b01, 32'hDEADBEEF, 1'b1};
    vecs[8]  = '{2'b10, 2'b01, 8'h00, 8'h10, 4'h3, 32'h11223344, 2'b10, 1'b0, 1'b0, 4'hC, 8'h10, 32'h11223344, 2'b00, 32'h0,        1'b1};
    vecs[9]  = '{2'b10, 2'b11, 8'h00, 8'h10, 4'hF, 32'h0,        2'b10, 1'b0, 1'b1, 4'h0, 8'h10, 32'h0,        2'b10, 32'h0,        1'b0};
    vecs[10] = '{2'b00, 2'b11, 8'h00, 8'h00, 4'hF, 32'h0,        2'b00, 1'b1, 1'b1, 4'hF, 8'h00, 32'h0,        2'b10, 32'hFFFF3344, 1'b1};
    vecs[11] = '{2'b11, 2'b11, 8'h01, 8'h02, 4'hF, 32'h0,        2'b01, 1'b0, 1'b1, 4'h0, 8'h01, WD0,          2'b00, 32'h0,        1'b1};
    vecs[12] = '{2'b11, 2'b11, 8'h01, 8'h02, 4'hF, 32'h0,        2'b10, 1'b0, 1'b1, 4'h0, 8'h02, 32'h0,        2'b01, 32'hFFFFFFFF, 1'b1};
    vecs[13] = '{2'b00, 2'b11, 8'h00, 8'h00, 4'hF, 32'h0,        2'b00, 1'b1, 1'b1, 4'hF, 8'h00, 32'h0,        2'b10, 32'hFFFFFFFF, 1'b1};

    for (int a = 0; a < (1 << AW); a++) bank[a] = 32'hFFFFFFFF;
    bank[5]     = 32'hDEADBEEF;
    mem_rdata_i = '0;

    rst_ni     = 1'b0;
    init_req_i = 1'b0;
    req_i      = 2'b11;
    wen_i      = 2'b11;
    add_i      = {8'h22, 8'h11};
    be_i       = 8'hFF;
    wdata_i    = {32'h12345678, WD0};
    #2;
    check("rst_gnt", 32'(gnt_o), 32'h0);
    check("rst_rvalid", 32'(r_valid_o), 32'h0);
    check("rst_rdata", r_rdata_o, 32'h0);
    check("rst_busy", 32'(init_busy_o), 32'h0);
    check("rst_done", 32'(init_done_o), 32'h0);
    check("rst_csn", 32'(mem_csn_o), 32'h1);
    check("rst_wen", 32'(mem_wen_o), 32'h1);
    check("rst_ben", 32'(mem_ben_o), 32'hF);
    check("rst_add", 32'(mem_add_o), 32'h0);
    check("rst_wdata", mem_wdata_o, 32'h0);

    @(negedge clk);
    rst_ni = 1'b1;
    req_i  = 2'b00;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      req_i   = vecs[i].req;
      wen_i   = vecs[i].wen;
      add_i   = {vecs[i].add1, vecs[i].add0};
      be_i    = {vecs[i].be1, 4'hF};
      wdata_i = {vecs[i].wd1, WD0};
      #2;
      check($sformatf("v%0d_gnt", i), 32'(gnt_o), 32'(vecs[i].gnt));
      check($sformatf("v%0d_csn", i), 32'(mem_csn_o), 32'(vecs[i].csn));
      check($sformatf("v%0d_wen", i), 32'(mem_wen_o), 32'(vecs[i].mwen));
      check($sformatf("v%0d_ben", i), 32'(mem_ben_o), 32'(vecs[i].ben));
      check($sformatf("v%0d_add", i), 32'(mem_add_o), 32'(vecs[i].madd));
      check($sformatf("v%0d_wdata", i), mem_wdata_o, vecs[i].mwd);
      check($sformatf("v%0d_rvalid", i), 32'(r_valid_o), 32'(vecs[i].rvalid));
      if (vecs[i].chk) check($sformatf("v%0d_rdata", i), r_rdata_o, vecs[i].rdata);
      @(negedge clk);
    end

    // Init request alongside a port-0 grant in the same cycle.
    wdata_i    = {32'h0, WD0};
    be_i       = 8'hFF;
    wen_i      = 2'b11;
    req_i      = 2'b01;
    add_i      = {8'h00, 8'h03};
    init_req_i = 1'b1;
    #2;
    check("init_entry_gnt", 32'(gnt_o), 32'h1);
    check("init_entry_busy", 32'(init_busy_o), 32'h0);
    @(negedge clk);

    for (int i = 0; i < IW; i++) begin
      req_i      = 2'b11;
      add_i      = {8'h06, 8'h04};
      init_req_i = (i == 5);
      #2;
      check($sformatf("init%0d_gnt", i), 32'(gnt_o), 32'h0);
      check($sformatf("init%0d_busy", i), 32'(init_busy_o), 32'h1);
      check($sformatf("init%0d_done", i), 32'(init_done_o), 32'h0);
      check($sformatf("init%0d_csn", i), 32'(mem_csn_o), 32'h0);
      check($sformatf("init%0d_wen", i), 32'(mem_wen_o), 32'h0);
      check($sformatf("init%0d_ben", i), 32'(mem_ben_o), 32'h0);
      check($sformatf("init%0d_add", i), 32'(mem_add_o), i);
      check($sformatf("init%0d_wdata", i), mem_wdata_o, 32'h0);
      if (i == 0) check("init0_rvalid", 32'(r_valid_o), 32'h1);
      @(negedge clk);
    end

    init_req_i = 1'b0;
    req_i      = 2'b11;
    add_i      = {8'h00, 8'h00};
    #2;
    check("done_pulse", 32'(init_done_o), 32'h1);
    check("done_busy", 32'(init_busy_o), 32'h0);
    check("done_gnt", 32'(gnt_o), 32'h2);
    @(negedge clk);

    req_i = 2'b01;
    add_i = {8'h00, 8'h01};
    #2;
    check("post_done", 32'(init_done_o), 32'h0);
    check("rd0_rvalid", 32'(r_valid_o), 32'h2);
    check("rd0_rdata", r_rdata_o, 32'h0);
    @(negedge clk);

    pulses = 0;
    for (int a = 2; a <= IW; a++) begin
      req_i = (a < IW) ? 2'b01 : 2'b00;
      add_i = {8'h00, 8'(a)};
      #2;
      if (init_done_o) pulses++;
      check($sformatf("rd%0d_rvalid", a - 1), 32'(r_valid_o), 32'h1);
      check($sformatf("rd%0d_rdata", a - 1), r_rdata_o, 32'h0);
      @(negedge clk);
    end
    check("single_done_pulse", 32'(pulses), 32'h0);

    // Reset in the middle of a sweep.
    req_i      = 2'b00;
    init_req_i = 1'b1;
    #2;
    @(negedge clk);
    init_req_i = 1'b0;
    for (int k = 0; k < 7; k++) @(negedge clk);
    #2;
    check("mid_add7", 32'(mem_add_o), 32'h7);
    check("mid_busy", 32'(init_busy_o), 32'h1);
    rst_ni = 1'b0;
    req_i  = 2'b01;
    #1;
    check("mid_rst_csn", 32'(mem_csn_o), 32'h1);
    check("mid_rst_busy", 32'(init_busy_o), 32'h0);
    check("mid_rst_gnt", 32'(gnt_o), 32'h0);
    check("mid_rst_add", 32'(mem_add_o), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    req_i  = 2'b00;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      #2;
      if (init_done_o || init_busy_o) pulses++;
      @(negedge clk);
    end
    check("after_rst_idle", 32'(pulses), 32'h0);

    init_req_i = 1'b1;
    #2;
    @(negedge clk);
    init_req_i = 1'b0;
    #2;
    check("restart_busy", 32'(init_busy_o), 32'h1);
    check("restart_add", 32'(mem_add_o), 32'h0);
    n = 0;
    while (!init_done_o && n < 40) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("restart_done_delay", 32'(n), 32'(IW));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
